// File: rtl/ov5640_sccb_responder.sv
// SCCB camera-side responder: decodes 16-bit-address register writes and
// reads on an oversampled SCL/SDA pair, serving reads from an external model.
module ov5640_sccb_responder #(
   parameter logic [7:0] DEVICE_ID = 8'h78,
   parameter int         FILT_LEN  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe,
   output logic        wr_valid,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        busy,
   output logic        err_nack
);
   typedef enum logic [2:0] {IDLE, ID, ADH, ADL, WR, RD, IGNORE} state_t;
   localparam logic [2:0] FMAX = 3'(FILT_LEN - 1);

   logic [1:0] scl_s, sda_s;
   logic [2:0] scl_c, sda_c;
   logic       scl_f, sda_f, scl_q, sda_q;

   // A level is accepted only after FILT_LEN consecutive differing samples
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_s <= 2'b11;
         sda_s <= 2'b11;
         scl_c <= '0;
         sda_c <= '0;
         scl_f <= 1'b1;
         sda_f <= 1'b1;
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_s <= {scl_s[0], scl_i};
         sda_s <= {sda_s[0], sda_i};
         scl_q <= scl_f;
         sda_q <= sda_f;
         if (scl_s[1] == scl_f) begin
            scl_c <= '0;
         end else if (scl_c == FMAX) begin
            scl_f <= scl_s[1];
            scl_c <= '0;
         end else begin
            scl_c <= scl_c + 3'd1;
         end
         if (sda_s[1] == sda_f) begin
            sda_c <= '0;
         end else if (sda_c == FMAX) begin
            sda_f <= sda_s[1];
            sda_c <= '0;
         end else begin
            sda_c <= sda_c + 3'd1;
         end
      end
   end

   logic scl_rise, scl_fall, start_c, stop_c;
   assign scl_rise = scl_f & ~scl_q;
   assign scl_fall = ~scl_f & scl_q;
   assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

   state_t      state;
   logic [3:0]  bitcnt;
   logic [6:0]  shreg;
   logic [7:0]  addr_hi;
   logic [15:0] ptr;
   logic        ack_pend, in_ack, load, mack;
   logic [7:0]  rx_byte;
   logic        rx_state;

   assign rx_byte  = {shreg, sda_f};
   assign rx_state = (state == ID) || (state == ADH) ||
                     (state == ADL) || (state == WR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         bitcnt   <= '0;
         shreg    <= '0;
         addr_hi  <= '0;
         ptr      <= '0;
         ack_pend <= 1'b0;
         in_ack   <= 1'b0;
         load     <= 1'b0;
         mack     <= 1'b0;
         sda_oe   <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         rd_addr  <= '0;
         busy     <= 1'b0;
         err_nack <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         if (start_c || stop_c) begin
            busy     <= start_c;
            state    <= start_c ? ID : IDLE;
            bitcnt   <= '0;
            sda_oe   <= 1'b0;
            ack_pend <= 1'b0;
            in_ack   <= 1'b0;
            load     <= 1'b0;
            mack     <= 1'b0;
         end else if (scl_rise) begin
            if (rx_state && !in_ack) begin
               shreg  <= rx_byte[6:0];
               bitcnt <= bitcnt + 4'd1;
               if (bitcnt == 4'd7) begin
                  bitcnt   <= '0;
                  ack_pend <= 1'b1;
                  case (state)
                     ID: begin
                        if (rx_byte[7:1] == DEVICE_ID[7:1]) begin
                           state <= rx_byte[0] ? RD : ADH;
                           if (rx_byte[0]) rd_addr <= ptr;
                        end else begin
                           ack_pend <= 1'b0;
                           err_nack <= 1'b1;
                           state    <= IGNORE;
                        end
                     end
                     ADH: begin
                        addr_hi <= rx_byte;
                        state   <= ADL;
                     end
                     ADL: begin
                        ptr   <= {addr_hi, rx_byte};
                        state <= WR;
                     end
                     default: begin
                        wr_valid <= 1'b1;
                        wr_addr  <= ptr;
                        wr_data  <= rx_byte;
                        ptr      <= ptr + 16'd1;
                     end
                  endcase
               end
            end else if (state == RD && mack) begin
               // Master acknowledge slot after a read byte
               mack <= 1'b0;
               if (!sda_f) begin
                  ptr     <= ptr + 16'd1;
                  rd_addr <= ptr + 16'd1;
                  load    <= 1'b1;
               end else begin
                  state <= IGNORE;
               end
            end
         end else if (scl_fall) begin
            if (ack_pend) begin
               sda_oe   <= 1'b1;
               ack_pend <= 1'b0;
               in_ack   <= 1'b1;
            end else if (in_ack || load) begin
               in_ack <= 1'b0;
               load   <= 1'b0;
               if (state == RD) begin
                  shreg  <= rd_data[6:0];
                  sda_oe <= ~rd_data[7];
                  bitcnt <= 4'd1;
               end else begin
                  sda_oe <= 1'b0;
               end
            end else if (state == RD && !mack) begin
               if (bitcnt == 4'd8) begin
                  sda_oe <= 1'b0;
                  mack   <= 1'b1;
               end else begin
                  sda_oe <= ~shreg[6];
                  shreg  <= {shreg[5:0], 1'b0};
                  bitcnt <= bitcnt + 4'd1;
               end
            end
         end
      end
   end
endmodule
